// File: rtl/sram_array_1r1w_init_ext_pkg.sv
// Shared definitions for the 1R1W SRAM model: FSM encoding, sizing helper and
// elaboration-time parameter legality.
package sram_model_pkg;

  localparam logic [0:0] ST_SWEEP = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef logic [0:0] sram_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int depth, input int width,
                                      input int mask_w, input int read_lat);
    return ((read_lat == 1) || (read_lat == 2)) &&
           (mask_w > 0) && ((width % mask_w) == 0) &&
           is_pow2(depth);
  endfunction

endpackage

// File: rtl/sram_array_1r1w_init_ext_if.sv
// Port bundle of the 1R1W SRAM: clear control, read port R0 and write port W0.
interface sram_array_1r1w_init_ext_if #(
  parameter int AW     = 10,
  parameter int WIDTH  = 384,
  parameter int MASK_W = 16
);

  // No backpressure anywhere: a read is accepted in every cycle with R0_en=1
  // while init_done=1 and answers with a one-cycle R0_valid pulse a fixed
  // latency later; a write with W0_en=1 while init_done=1 always commits.
  // clear_req is a one-cycle pulse honoured only while init_done=1.
  logic              init_done;
  logic              clear_req;
  logic              R0_en;
  logic [AW-1:0]     R0_addr;
  logic              R0_valid;
  logic [WIDTH-1:0]  R0_rdata;
  logic              W0_en;
  logic [AW-1:0]     W0_addr;
  logic [MASK_W-1:0] W0_mask;
  logic [WIDTH-1:0]  W0_wdata;

  modport master (
    output clear_req, R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_wdata,
    input  init_done, R0_valid, R0_rdata
  );

  modport slave (
    input  clear_req, R0_en, R0_addr, W0_en, W0_addr, W0_mask, W0_wdata,
    output init_done, R0_valid, R0_rdata
  );

endinterface

// File: rtl/sram_array_1r1w_init_ext_mask_merge.sv
// Combinational per-segment merge: segment i comes from new_i when mask_i[i]
// is set, otherwise from old_i.
module sram_mask_merge #(
  parameter int WIDTH  = 384,
  parameter int MASK_W = 16
) (
  input  logic [WIDTH-1:0]  old_i,
  input  logic [WIDTH-1:0]  new_i,
  input  logic [MASK_W-1:0] mask_i,
  output logic [WIDTH-1:0]  merged_o
);

  localparam int SEG = WIDTH / MASK_W;

  for (genvar i = 0; i < MASK_W; i++) begin : g_seg
    assign merged_o[i*SEG +: SEG] = mask_i[i] ? new_i[i*SEG +: SEG]
                                              : old_i[i*SEG +: SEG];
  end

endmodule

// File: rtl/sram_array_1r1w_init_ext.sv
// Behavioural 1R1W SRAM with masked writes, hardware clear sweep after reset
// or on request, read latency 1 or 2 and optional same-cycle write bypass.
module sram_array_1r1w_init_ext
  import sram_model_pkg::*;
#(
  parameter int               DEPTH    = 1024,
  parameter int               WIDTH    = 384,
  parameter int               MASK_W   = 16,
  parameter int               READ_LAT = 1,
  parameter int               BYPASS   = 1,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  localparam int              AW       = clog2(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset_n,
  sram_array_1r1w_init_ext_if.slave    bus,
  output sram_state_t                  dbg_state_o
);

  if (!params_legal(DEPTH, WIDTH, MASK_W, READ_LAT)) begin : g_bad_params
    $error("sram_array_1r1w_init_ext: illegal DEPTH/WIDTH/MASK_W/READ_LAT");
  end

  sram_state_t      state_q, state_d;
  logic [AW-1:0]    sweep_addr_q, sweep_addr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             ready;
  logic             rd_fire;
  logic             wr_fire;
  logic             bypass_hit;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;
  logic [WIDTH-1:0] rd_old;
  logic [WIDTH-1:0] rd_merged;
  logic [WIDTH-1:0] rd_data;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  assign ready         = (state_q == ST_READY);
  assign rd_fire       = bus.R0_en && ready;
  assign wr_fire       = bus.W0_en && ready;
  assign bus.init_done = ready;
  assign dbg_state_o   = state_q;

  // Sweep address wraps to zero after DEPTH-1 because DEPTH is a power of two.
  always_comb begin
    state_d      = state_q;
    sweep_addr_d = sweep_addr_q;
    case (state_q)
      ST_SWEEP: begin
        sweep_addr_d = sweep_addr_q + 1'b1;
        if (sweep_addr_q == AW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      default: begin
        if (bus.clear_req) begin
          state_d      = ST_SWEEP;
          sweep_addr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_SWEEP;
      sweep_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_addr_q <= sweep_addr_d;
    end
  end

  assign wr_old = mem_q[bus.W0_addr];
  assign rd_old = mem_q[bus.R0_addr];

  sram_mask_merge #(
    .WIDTH  (WIDTH),
    .MASK_W (MASK_W)
  ) u_wr_merge (
    .old_i    (wr_old),
    .new_i    (bus.W0_wdata),
    .mask_i   (bus.W0_mask),
    .merged_o (wr_merged)
  );

  sram_mask_merge #(
    .WIDTH  (WIDTH),
    .MASK_W (MASK_W)
  ) u_byp_merge (
    .old_i    (rd_old),
    .new_i    (bus.W0_wdata),
    .mask_i   (bus.W0_mask),
    .merged_o (rd_merged)
  );

  // The sweep owns the single array write port; user writes only land in READY.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.W0_addr;
    mem_wdata = wr_merged;
    if (state_q == ST_SWEEP) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_addr_q;
      mem_wdata = INIT_VAL;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bypass_hit = (BYPASS != 0) && wr_fire && (bus.W0_addr == bus.R0_addr);
  assign rd_data    = bypass_hit ? rd_merged : rd_old;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_fire;
      if (rd_fire) begin
        s1_data_q <= rd_data;
      end
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign bus.R0_valid = s1_valid_q;
    assign bus.R0_rdata = s1_data_q;
  end else begin : g_lat2
    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;

    // Data registers only load on a valid stage so R0_rdata holds between results.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign bus.R0_valid = s2_valid_q;
    assign bus.R0_rdata = s2_data_q;
  end

endmodule

// File: tb/tb_sram_array_1r1w_init_ext.sv
// Bench driving two SRAM instances (latency 1 with bypass, latency 2 without)
// with identical stimulus and checking both against an array-level model.
module tb_sram_array_1r1w_init_ext;

  localparam int DEPTH  = 1024;
  localparam int WIDTH  = 384;
  localparam int MASK_W = 16;
  localparam int SEG    = WIDTH / MASK_W;
  localparam int AW     = 10;
  localparam logic [WIDTH-1:0] INIT = {12{32'hA5C3_0F1E}};

  logic              clock;
  logic              reset_n;
  logic              clr;
  logic              r_en;
  logic [AW-1:0]     r_addr;
  logic              w_en;
  logic [AW-1:0]     w_addr;
  logic [MASK_W-1:0] w_mask;
  logic [WIDTH-1:0]  w_data;
  logic [0:0]        dbg_a;
  logic [0:0]        dbg_b;

  sram_array_1r1w_init_ext_if #(.AW(AW), .WIDTH(WIDTH), .MASK_W(MASK_W)) if_a ();
  sram_array_1r1w_init_ext_if #(.AW(AW), .WIDTH(WIDTH), .MASK_W(MASK_W)) if_b ();

  assign if_a.clear_req = clr;
  assign if_a.R0_en     = r_en;
  assign if_a.R0_addr   = r_addr;
  assign if_a.W0_en     = w_en;
  assign if_a.W0_addr   = w_addr;
  assign if_a.W0_mask   = w_mask;
  assign if_a.W0_wdata  = w_data;
  assign if_b.clear_req = clr;
  assign if_b.R0_en     = r_en;
  assign if_b.R0_addr   = r_addr;
  assign if_b.W0_en     = w_en;
  assign if_b.W0_addr   = w_addr;
  assign if_b.W0_mask   = w_mask;
  assign if_b.W0_wdata  = w_data;

  sram_array_1r1w_init_ext #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_W(MASK_W),
    .READ_LAT(1), .BYPASS(1), .INIT_VAL(INIT)
  ) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(if_a), .dbg_state_o(dbg_a)
  );

  sram_array_1r1w_init_ext #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_W(MASK_W),
    .READ_LAT(2), .BYPASS(0), .INIT_VAL(INIT)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(if_b), .dbg_state_o(dbg_b)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model / scoreboard ----------------
  logic [WIDTH-1:0] model_mem [DEPTH];
  bit               model_ready;
  int               sweep_left;
  int               cyc;
  logic [WIDTH-1:0] exp_q_a[$];
  logic [WIDTH-1:0] exp_q_b[$];
  int               due_q_a[$];
  int               due_q_b[$];
  logic [WIDTH-1:0] last_a;
  logic [WIDTH-1:0] last_b;
  int               checks;
  int               errors;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] spec_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [MASK_W-1:0] m);
    logic [WIDTH-1:0] bm;
    for (int b = 0; b < WIDTH; b++) bm[b] = m[b / SEG];
    return (old_w & ~bm) | (new_w & bm);
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [WIDTH-1:0] w;
    for (int k = 0; k < WIDTH / 32; k++) w[k*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic model_reset();
    model_ready = 1'b0;
    sweep_left  = DEPTH;
    exp_q_a.delete(); exp_q_b.delete();
    due_q_a.delete(); due_q_b.delete();
    last_a = '0;
    last_b = '0;
  endtask

  task automatic check_outputs();
    bit va, vb;
    va = (due_q_a.size() > 0) && (due_q_a[0] == cyc);
    vb = (due_q_b.size() > 0) && (due_q_b[0] == cyc);
    if (va) begin void'(due_q_a.pop_front()); last_a = exp_q_a.pop_front(); end
    if (vb) begin void'(due_q_b.pop_front()); last_b = exp_q_b.pop_front(); end
    chk("a_valid",     WIDTH'(if_a.R0_valid),  WIDTH'(va));
    chk("a_rdata",     if_a.R0_rdata,          last_a);
    chk("a_init_done", WIDTH'(if_a.init_done), WIDTH'(model_ready));
    chk("a_state",     WIDTH'(dbg_a),          WIDTH'(model_ready));
    chk("b_valid",     WIDTH'(if_b.R0_valid),  WIDTH'(vb));
    chk("b_rdata",     if_b.R0_rdata,          last_b);
    chk("b_init_done", WIDTH'(if_b.init_done), WIDTH'(model_ready));
    chk("b_state",     WIDTH'(dbg_b),          WIDTH'(model_ready));
  endtask

  // One clock: model applies the current inputs, edge happens, outputs checked.
  task automatic cycle();
    logic [WIDTH-1:0] old_w;
    logic [WIDTH-1:0] byp_w;
    if (reset_n && model_ready) begin
      if (r_en) begin
        old_w = model_mem[r_addr];
        byp_w = (w_en && w_addr == r_addr) ? spec_merge(old_w, w_data, w_mask) : old_w;
        exp_q_a.push_back(byp_w); due_q_a.push_back(cyc + 1);
        exp_q_b.push_back(old_w); due_q_b.push_back(cyc + 2);
      end
      if (w_en) model_mem[w_addr] = spec_merge(model_mem[w_addr], w_data, w_mask);
      if (clr) begin
        model_ready = 1'b0;
        sweep_left  = DEPTH;
      end
    end else if (reset_n) begin
      sweep_left--;
      if (sweep_left == 0) begin
        model_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
    check_outputs();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    clr  = 1'b0;
    r_en = 1'b0;
    w_en = 1'b0;
  endtask

  task automatic read_and_drain(input logic [AW-1:0] a);
    r_en = 1'b1; r_addr = a;
    cycle();
    idle();
    repeat (3) cycle();
  endtask

  // Random port activity while sweeping; bounded wait for init_done.
  task automatic run_sweep(input string tag);
    int n;
    n = 0;
    while (if_a.init_done !== 1'b1 && n < DEPTH + 8) begin
      r_en   = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 15));
      w_en   = 1'($urandom_range(0, 1));
      w_addr = AW'($urandom_range(0, 15));
      w_mask = MASK_W'($urandom());
      w_data = rand_word();
      clr    = ($urandom_range(0, 31) == 0);
      cycle();
      n++;
    end
    idle();
    chk(tag, WIDTH'(n), WIDTH'(DEPTH));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [WIDTH-1:0] exp_w;
    logic [WIDTH-1:0] nd;
    checks = 0; errors = 0; cyc = 0;
    idle();
    r_addr = '0; w_addr = '0; w_mask = '0; w_data = '0;
    model_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_a_init_done", WIDTH'(if_a.init_done), '0);
    chk("rst_a_valid",     WIDTH'(if_a.R0_valid),  '0);
    chk("rst_a_rdata",     if_a.R0_rdata,          '0);
    chk("rst_b_rdata",     if_b.R0_rdata,          '0);
    cycle(); cycle();
    reset_n = 1'b1;
    run_sweep("reset_sweep_len");

    read_and_drain(10'h3FF);
    chk("rd_3ff_a", if_a.R0_rdata, INIT);
    chk("rd_3ff_b", if_b.R0_rdata, INIT);

    w_en = 1'b1; w_addr = 10'd5; w_mask = 16'h0001; w_data = '1;
    cycle(); idle();
    read_and_drain(10'd5);
    exp_w = INIT;
    exp_w[SEG-1:0] = '1;
    chk("mask_seg0_a", if_a.R0_rdata, exp_w);
    chk("mask_seg0_b", if_b.R0_rdata, exp_w);

    nd = rand_word();
    w_en = 1'b1; w_addr = 10'd9; w_mask = 16'h8000; w_data = nd;
    r_en = 1'b1; r_addr = 10'd9;
    cycle(); idle();
    repeat (3) cycle();
    exp_w = INIT;
    exp_w[WIDTH-1 -: SEG] = nd[WIDTH-1 -: SEG];
    chk("bypass_a",    if_a.R0_rdata, exp_w);
    chk("no_bypass_b", if_b.R0_rdata, INIT);

    for (int k = 1; k <= 3; k++) begin
      w_en = 1'b1; w_addr = AW'(k); w_mask = '1; w_data = rand_word();
      cycle();
    end
    idle();
    for (int k = 1; k <= 3; k++) begin
      r_en = 1'b1; r_addr = AW'(k);
      cycle();
    end
    idle();
    repeat (3) cycle();

    for (int i = 0; i < 600; i++) begin
      r_en   = 1'($urandom_range(0, 1));
      r_addr = AW'($urandom_range(0, 15));
      w_en   = 1'($urandom_range(0, 1));
      w_addr = AW'($urandom_range(0, 15));
      w_mask = ($urandom_range(0, 3) == 0) ? '0 : MASK_W'($urandom());
      w_data = rand_word();
      cycle();
    end
    idle();
    repeat (3) cycle();

    w_en = 1'b1; w_addr = 10'd7; w_mask = '1; w_data = rand_word();
    cycle();
    w_en = 1'b0; clr = 1'b1; r_en = 1'b1; r_addr = 10'd7;
    cycle(); idle();
    run_sweep("clear_sweep_len");
    for (int k = 0; k < 16; k++) begin
      r_en = 1'b1; r_addr = AW'(k);
      cycle();
    end
    idle();
    read_and_drain(10'd7);
    chk("clr_addr7_a", if_a.R0_rdata, INIT);
    chk("clr_addr7_b", if_b.R0_rdata, INIT);

    clr = 1'b1;
    cycle(); idle();
    repeat (500) cycle();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_a_init_done", WIDTH'(if_a.init_done), '0);
    chk("midrst_a_rdata",     if_a.R0_rdata,          '0);
    chk("midrst_b_rdata",     if_b.R0_rdata,          '0);
    chk("midrst_b_valid",     WIDTH'(if_b.R0_valid),  '0);
    cycle(); cycle();
    reset_n = 1'b1;
    run_sweep("restart_sweep_len");
    read_and_drain(10'd0);
    chk("restart_addr0_a", if_a.R0_rdata, INIT);
    chk("restart_addr0_b", if_b.R0_rdata, INIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_array_1r1w_init_ext.md
Name: sram_array_1r1w_init_ext

Overview:
- Parametrised behavioural SRAM model: one read port, one independent write port, per-segment write mask.
- Hardware clear sweep after reset and on request, so the array always starts from a defined value.
- Configurable read latency of 1 or 2 and optional same-cycle write-to-read bypass.
- Used as the generated-memory model for next-generation cache and predictor arrays, where read and write ports are separate.

Parameters:
- DEPTH, 1024, number of entries; power of two, at least 2.
- WIDTH, 384, data bits per entry.
- MASK_W, 16, write-mask bits; WIDTH is divisible by MASK_W; segment width SEG = WIDTH/MASK_W.
- READ_LAT, 1, read latency in cycles; legal values are 1 and 2.
- BYPASS, 1, when 1 a same-cycle, same-address write is forwarded to the read.
- INIT_VAL, 0, WIDTH-bit value written to every entry by the clear sweep.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- init_done  out  1  high when the array is ready; low during a sweep.
- clear_req  in  1  one-cycle pulse that starts a clear sweep.
- R0_en  in  1  read enable.
- R0_addr  in  clog2(DEPTH)  read address.
- R0_valid  out  1  R0_rdata carries the result of a read.
- R0_rdata  out  WIDTH  read data.
- W0_en  in  1  write enable.
- W0_addr  in  clog2(DEPTH)  write address.
- W0_mask  in  MASK_W  bit i enables segment [i*SEG +: SEG].
- W0_wdata  in  WIDTH  write data.

Behaviour:
- Reset (reset_n low, asynchronous):
  - init_done=0, R0_valid=0, R0_rdata=0, all pipeline valids cleared, FSM enters SWEEP with sweep_addr=0.
  - Array contents are not reset directly; only the sweep initialises them.
- FSM states: SWEEP and READY.
  - SWEEP: each cycle writes INIT_VAL to entry sweep_addr, then increments sweep_addr.
  - When sweep_addr==DEPTH-1 is written, the next state is READY; the sweep takes exactly DEPTH cycles.
  - READY: init_done=1.
  - clear_req in READY: next cycle enters SWEEP with sweep_addr=0 and init_done=0.
  - clear_req during SWEEP is ignored; no restart.
  - reset_n asserted mid-sweep restarts the sweep from address 0 after release.
- Port gating during SWEEP:
  - R0_en and W0_en are ignored: no array write, no R0_valid.
  - A read issued in the same cycle as clear_req is still serviced normally.
  - Read pipeline entries already in flight complete normally.
- Write: in READY with W0_en=1, each segment with its mask bit set is updated at the clock edge; unmasked segments keep their value. W0_mask=0 is a no-op.
- Read:
  - Issued in a cycle with R0_en=1 in READY.
  - R0_valid pulses high exactly READ_LAT cycles later, with data equal to the array contents at the issue edge.
  - Back-to-back reads give one result per cycle at full throughput.
- Same-cycle, same-address read and write:
  - BYPASS=1: result is a per segment merge: W0_wdata where W0_mask is set, old contents elsewhere.
  - BYPASS=0: result is the old contents.
  - Writes in later cycles are never visible to a read already issued.
- R0_rdata holds its last value when R0_valid=0; there is no garbage or random data.
- Out-of-range addresses are impossible because DEPTH is a power of two.
- No backpressure on either port.

Decomposition:
- Shared package sram_model_pkg holds:
  - the state encoding (SWEEP=0, READY=1);
  - a clog2 helper function;
  - legality checks on the parameters (READ_LAT in {1,2}; WIDTH divisible by MASK_W; DEPTH a power of two), which stop elaboration with an error.
- One sub-module, sram_mask_merge: purely combinational. It takes old data, new data and mask and produces the merged word. It is used by both the write path and the bypass path.

Test Plan:
- Reset release, DEPTH=1024 -> init_done rises after exactly 1024 cycles; a read of address 0x3FF then returns INIT_VAL with R0_valid exactly READ_LAT cycles later.
- Write address 5 with mask 0x0001 and data all-ones, then read address 5 -> bits [23:0]=0xFFFFFF, all other bits equal INIT_VAL.
- BYPASS=1: same-cycle write to address 9 with mask 0x8000 and read of address 9 -> bits [383:360] take the new data, the rest old. BYPASS=0 -> entire word old.
- READ_LAT=2, reads of addresses 1, 2, 3 on consecutive cycles -> R0_valid high for 3 cycles, starting 2 cycles after the first read, data in address order.
- clear_req in READY after writing address 7 -> init_done low for 1024 cycles. R0_en/W0_en during the sweep produce no R0_valid and no write. Address 7 afterwards reads INIT_VAL.
- reset_n pulsed low at sweep cycle 500 -> outputs zero immediately. After release, the full 1024-cycle sweep restarts from address 0.
